pipe_alu: RTL and testbench

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 49 ++++
 rtl/pipe_alu.sv | 87 ++++++++
 tb/tb_pipe_alu.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and flag bit indices shared by the ALU files
package alu_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [4:0] OP_NOTA  = 5'b00000;
  localparam logic [4:0] OP_NOTB  = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_ADC   = 5'b00011;
  localparam logic [4:0] OP_INC   = 5'b00100;
  localparam logic [4:0] OP_BSUBA = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_DEC   = 5'b00111;
  localparam logic [4:0] OP_ZERO  = 5'b01000;
  localparam logic [4:0] OP_PASS  = 5'b01001;
  localparam logic [4:0] OP_AND   = 5'b01010;
  localparam logic [4:0] OP_OR    = 5'b01011;
  localparam logic [4:0] OP_XOR   = 5'b01100;
  localparam logic [4:0] OP_SLL   = 5'b01101;
  localparam logic [4:0] OP_SRL   = 5'b01110;
  localparam logic [4:0] OP_SRA   = 5'b01111;
  localparam int F_ZERO = 0;
  localparam int F_NEG  = 1;
  localparam int F_COUT = 2;
  localparam int F_OVF  = 3;
  localparam int F_ERR  = 4;
  function automatic logic is_shift(input logic [4:0] op);
    return op == OP_SLL || op == OP_SRL || op == OP_SRA;
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU datapath with flag generation
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       fsec,
  input  logic             carry,
  output logic [WIDTH-1:0] res,
  output logic [4:0]       flags
);
  logic             arith;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH:0]   sum;
  assign arith = fsec >= OP_ADD && fsec <= OP_DEC;
  assign x = fsec == OP_BSUBA ? b : a;
  assign y = fsec == OP_ADD || fsec == OP_ADC ? b :
             fsec == OP_INC ? '0 :
             fsec == OP_BSUBA ? ~a :
             fsec == OP_SUB ? ~b :
             ~{{(WIDTH-1){1'b0}}, 1'b1};
  assign cin = fsec == OP_ADC ? carry : fsec == OP_INC || fsec == OP_BSUBA || fsec == OP_SUB || fsec == OP_DEC;
  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
  always_comb begin
    res = '0;
    case (fsec)
      OP_NOTA: res = ~a;
      OP_NOTB: res = ~b;
      OP_ADD, OP_ADC, OP_INC, OP_BSUBA, OP_SUB, OP_DEC: res = sum[WIDTH-1:0];
      OP_PASS, OP_SLL, OP_SRL, OP_SRA: res = a;
      OP_AND: res = a & b;
      OP_OR: res = a | b;
      OP_XOR: res = a ^ b;
      default: res = '0;
    endcase
  end
  always_comb begin
    flags = '0;
    flags[F_ZERO] = res == '0;
    flags[F_NEG] = res[WIDTH-1];
    flags[F_COUT] = arith & sum[WIDTH];
    flags[F_OVF] = arith & (x[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != x[WIDTH-1]);
    flags[F_ERR] = fsec[4];
  end
endmodule

// File: rtl/pipe_alu.sv
// pipe_alu: handshaked ALU with a bit-serial shifter and held result registers
module pipe_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       fsec,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] fout,
  output logic [4:0]       flags
);
  state_t             state_q;
  state_t             state_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   shifted;
  logic [4:0]         op_q;
  logic [4:0]         sflags;
  logic [WIDTH-1:0]   core_res;
  logic [4:0]         core_flags;
  logic               xfer;
  logic               bit_out;
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a(a),
    .b(b),
    .fsec(fsec),
    .carry(carry),
    .res(core_res),
    .flags(core_flags)
  );
  assign shamt = b[SHAMT_W-1:0];
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign xfer = in_valid & in_ready;
  assign shifted = op_q == OP_SLL ? {sreg[WIDTH-2:0], 1'b0} :
                   op_q == OP_SRL ? {1'b0, sreg[WIDTH-1:1]} :
                   {sreg[WIDTH-1], sreg[WIDTH-1:1]};
  assign bit_out = op_q == OP_SLL ? sreg[WIDTH-1] : sreg[0];
  always_comb begin
    sflags = '0;
    sflags[F_ZERO] = shifted == '0;
    sflags[F_NEG] = shifted[WIDTH-1];
    sflags[F_COUT] = bit_out;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = !xfer ? IDLE : is_shift(fsec) && shamt != '0 ? SHIFT : DONE;
      SHIFT: state_d = cnt_q == SHAMT_W'(1) ? DONE : SHIFT;
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sreg <= '0;
      op_q <= OP_ZERO;
      fout <= '0;
      flags <= '0;
    end else if (xfer) begin
      cnt_q <= shamt;
      sreg <= a;
      op_q <= fsec;
      fout <= core_res;
      flags <= core_flags;
    end else if (state_q == SHIFT) begin
      cnt_q <= cnt_q - SHAMT_W'(1);
      sreg <= shifted;
      if (cnt_q == SHAMT_W'(1)) begin
        fout <= shifted;
        flags <= sflags;
      end
    end
  end
endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu: directed self-checking bench for pipe_alu at 64 and 16 bits
module tb_pipe_alu;
  import alu_pkg::*;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  fsec;
  logic        carry;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fout;
  logic [4:0]  flags;
  logic        iv16;
  logic        ir16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [4:0]  f16;
  logic        c16;
  logic        ov16;
  logic        or16;
  logic [15:0] fout16;
  logic [4:0]  flags16;
  int          checks;
  int          errors;
  int          lat;
  logic        ir_low;
  pipe_alu #(.WIDTH(64)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .fsec(fsec),
    .carry(carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .fout(fout),
    .flags(flags)
  );
  pipe_alu #(.WIDTH(16)) dut16 (
    .clk(clk),
    .rst(rst),
    .in_valid(iv16),
    .in_ready(ir16),
    .a(a16),
    .b(b16),
    .fsec(f16),
    .carry(c16),
    .out_valid(ov16),
    .out_ready(or16),
    .fout(fout16),
    .flags(flags16)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [63:0] ta, input logic [63:0] tb, input logic [4:0] op, input logic c);
    @(negedge clk);
    a = ta;
    b = tb;
    fsec = op;
    carry = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = ~ta;
    b = ~tb;
    fsec = op ^ 5'b00011;
    carry = ~c;
    lat = 0;
    ir_low = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) ir_low = 1'b0;
    end while (!out_valid && lat < 100);
  endtask
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_valid_after"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    fsec = '0;
    carry = 1'b0;
    iv16 = 1'b0;
    or16 = 1'b0;
    a16 = '0;
    b16 = '0;
    f16 = '0;
    c16 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fout", fout, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    run(64'd5, 64'd3, OP_SUB, 1'b0);
    chk("sub_lat", 64'(lat), 64'd1);
    chk("sub_fout", fout, 64'd2);
    chk("sub_flags", 64'(flags), 64'b00100);
    chk("sub_ready_low", 64'(ir_low), 64'd1);
    consume("sub");
    run(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 1'b0);
    chk("add_ovf_lat", 64'(lat), 64'd1);
    chk("add_ovf_fout", fout, 64'h8000_0000_0000_0000);
    chk("add_ovf_flags", 64'(flags), 64'b01010);
    consume("add_ovf");
    run(64'h8000_0000_0000_0001, 64'd4, OP_SRA, 1'b0);
    chk("sra_lat", 64'(lat), 64'd5);
    chk("sra_ready_low", 64'(ir_low), 64'd1);
    chk("sra_fout", fout, 64'hF800_0000_0000_0000);
    chk("sra_flags", 64'(flags), 64'b00010);
    consume("sra");
    run(64'h1234, 64'h5678, 5'b10101, 1'b0);
    chk("err_lat", 64'(lat), 64'd1);
    chk("err_fout", fout, 64'd0);
    chk("err_flags", 64'(flags), 64'b10001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_hold_valid", 64'(out_valid), 64'd1);
      chk("err_hold_fout", fout, 64'd0);
      chk("err_hold_flags", 64'(flags), 64'b10001);
    end
    consume("err");
    run(64'hE000_0000_0000_0001, 64'd3, OP_SLL, 1'b0);
    chk("sll_lat", 64'(lat), 64'd4);
    chk("sll_fout", fout, 64'd8);
    chk("sll_flags", 64'(flags), 64'b00100);
    consume("sll");
    run(64'h1234, 64'h40, OP_SRL, 1'b0);
    chk("srl0_lat", 64'(lat), 64'd1);
    chk("srl0_fout", fout, 64'h1234);
    chk("srl0_flags", 64'(flags), 64'b00000);
    consume("srl0");
    run(64'd0, 64'd9, OP_DEC, 1'b0);
    chk("dec_fout", fout, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dec_flags", 64'(flags), 64'b00010);
    consume("dec");
    run(64'd5, 64'd3, OP_BSUBA, 1'b0);
    chk("bsuba_fout", fout, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("bsuba_flags", 64'(flags), 64'b00010);
    consume("bsuba");
    run(64'hF0F0, 64'hFF00, OP_XOR, 1'b0);
    chk("xor_fout", fout, 64'h0FF0);
    chk("xor_flags", 64'(flags), 64'b00000);
    consume("xor");
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000;
    b = 64'd40;
    fsec = OP_SLL;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_fout", fout, 64'd0);
    chk("abort_flags", 64'(flags), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    run(64'hFF, 64'd0, OP_INC, 1'b0);
    chk("inc_lat", 64'(lat), 64'd1);
    chk("inc_fout", fout, 64'h100);
    chk("inc_flags", 64'(flags), 64'b00000);
    consume("inc");
    @(negedge clk);
    a16 = 16'hFFFF;
    b16 = 16'h0000;
    f16 = OP_ADC;
    c16 = 1'b1;
    iv16 = 1'b1;
    @(posedge clk);
    #1 iv16 = 1'b0;
    @(negedge clk);
    chk("w16_valid", 64'(ov16), 64'd1);
    chk("w16_fout", 64'(fout16), 64'd0);
    chk("w16_flags", 64'(flags16), 64'b00101);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
